// File: rtl/freq_synth_pkg.sv
// freq_synth_pkg: shared constants and types; FREQ_SYNTH_ROUND_EN selects the rounding divide
package freq_synth_pkg;
  localparam int unsigned DEF_REF_HZ = 10_000_000;
  localparam int DEF_ACC_W = 32;
`ifdef FREQ_SYNTH_ROUND_EN
  localparam int ITER_EXTRA = 1;
`else
  localparam int ITER_EXTRA = 0;
`endif
  localparam int DEF_ITERS = DEF_ACC_W + ITER_EXTRA;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_LOAD = 2'd2} state_e;
  typedef logic [DEF_ACC_W-1:0] tword_t;
endpackage

// File: rtl/freq_synth_if.sv
// freq_synth_if: frequency request handshake
interface freq_synth_if;
  logic        freq_valid;
  logic [31:0] freq_hz;
  logic        freq_ready;
  logic        freq_err;
  modport master (output freq_valid, freq_hz, input freq_ready, freq_err);
  modport slave (input freq_valid, freq_hz, output freq_ready, freq_err);
endinterface

// File: rtl/freq_synth_divider.sv
// freq_synth_divider: serial restoring divider, q = floor(dividend * 2^ITERS / DIVISOR), one bit per cycle
module freq_synth_divider
  import freq_synth_pkg::*;
#(
  parameter int unsigned DIVISOR = DEF_REF_HZ,
  parameter int ITERS = DEF_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      dividend,
  output logic             done,
  output logic [ITERS-1:0] q
);
  localparam int CW = $clog2(ITERS + 1);
  logic [32:0]   rem;
  logic [32:0]   shifted;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          take;
  assign shifted = rem << 1;
  assign take = shifted >= 33'(DIVISOR);
  // high during the final iteration so the caller can move to LOAD on the same edge
  assign done = busy && cnt == CW'(ITERS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem  <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {1'b0, dividend};
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= take ? shifted - 33'(DIVISOR) : shifted;
      q    <= {q[ITERS-2:0], take};
      cnt  <= cnt + CW'(1);
      busy <= !done;
    end
endmodule

// File: rtl/freq_synth.sv
// freq_synth: request FSM, serial divide and phase accumulator; FREQ_SYNTH_ROUND_EN rounds the tuning word
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter int unsigned REF_HZ = DEF_REF_HZ,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             en,
  freq_synth_if.slave      req,
  output logic             out_clk,
  output logic             out_tick,
  output logic [ACC_W-1:0] tuning_word
);
  localparam int ITERS = ACC_W + ITER_EXTRA;
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DIV = ST_DIV;
  localparam logic [1:0] LOAD = ST_LOAD;
  logic [1:0]       state;
  logic             accept;
  logic             too_high;
  logic             div_done;
  logic [ITERS-1:0] q;
  logic [ACC_W-1:0] q_word;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  assign req.freq_ready = state == IDLE;
  assign accept = req.freq_valid && req.freq_ready;
  assign too_high = {req.freq_hz, 1'b0} >= 33'(REF_HZ);
  assign sum = {1'b0, acc} + {1'b0, tuning_word};
  freq_synth_divider #(.DIVISOR(REF_HZ), .ITERS(ITERS)) u_div (
    .clk(ref_clk),
    .rst(rst),
    .start(accept && !too_high),
    .dividend(req.freq_hz),
    .done(div_done),
    .q(q)
  );
`ifdef FREQ_SYNTH_ROUND_EN
  assign q_word = ACC_W'((q + ITERS'(1)) >> 1);
`else
  assign q_word = q;
`endif
  always_ff @(posedge ref_clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      tuning_word  <= '0;
      req.freq_err <= 1'b0;
    end else begin
      req.freq_err <= accept && too_high;
      state        <= state == IDLE ? (accept && !too_high ? DIV : IDLE) :
                      state == DIV  ? (div_done ? LOAD : DIV) : IDLE;
      if (state == LOAD) tuning_word <= q_word;
    end
  // accumulator is never cleared on retune so the output stays phase-continuous
  always_ff @(posedge ref_clk or posedge rst)
    if (rst) begin
      acc      <= '0;
      out_clk  <= 1'b0;
      out_tick <= 1'b0;
    end else if (en) begin
      acc      <= sum[ACC_W-1:0];
      out_tick <= sum[ACC_W];
      out_clk  <= sum[ACC_W-1];
    end else begin
      out_tick <= 1'b0;
    end
endmodule

// File: tb/tb_freq_synth.sv
// tb_freq_synth: directed stimulus against a cycle-level arithmetic model of the synthesizer
module tb_freq_synth;
  import freq_synth_pkg::*;
  localparam int N = DEF_ACC_W + ITER_EXTRA;
  localparam longint unsigned REF = 10_000_000;
  localparam longint unsigned MOD = 64'd1 << 32;
`ifdef FREQ_SYNTH_ROUND_EN
  localparam longint unsigned W1M = 429496730;
  localparam longint unsigned WBND = 2147483219;
`else
  localparam longint unsigned W1M = 429496729;
  localparam longint unsigned WBND = 2147483218;
`endif
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   en = 1'b0;
  logic   out_clk;
  logic   out_tick;
  tword_t tuning_word;
  freq_synth_if rq();
  freq_synth dut (
    .ref_clk(clk),
    .rst(rst),
    .en(en),
    .req(rq),
    .out_clk(out_clk),
    .out_tick(out_tick),
    .tuning_word(tuning_word)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic longint unsigned word_for(input longint unsigned hz);
`ifdef FREQ_SYNTH_ROUND_EN
    return (((hz << 33) / REF) + 1) >> 1;
`else
    return (hz << 32) / REF;
`endif
  endfunction
  longint unsigned m_acc = 0, m_word = 0, m_new = 0, m_hz = 0;
  bit m_clk = 0, m_tick = 0, m_err = 0, m_pend = 0;
  int cyc = 0, m_load_at = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 0; m_word = 0; m_clk = 0; m_tick = 0; m_err = 0; m_pend = 0;
    end else begin
      cyc++;
      m_err = 0;
      if (en) begin
        m_acc += m_word;
        m_tick = m_acc >= MOD;
        m_acc %= MOD;
        m_clk = m_acc >= MOD / 2;
      end else m_tick = 0;
      if (!m_pend && rq.freq_valid) begin
        m_hz = rq.freq_hz;
        if (2 * m_hz >= REF) m_err = 1;
        else begin
          m_pend = 1;
          m_load_at = cyc + N + 1;
          m_new = word_for(m_hz);
        end
      end else if (m_pend && cyc == m_load_at) begin
        m_word = m_new;
        m_pend = 0;
      end
    end
  end
  always @(negedge clk)
    if (!rst) begin
      check("out_clk", out_clk, m_clk);
      check("out_tick", out_tick, m_tick);
      check("tuning_word", tuning_word, m_word);
      check("freq_ready", rq.freq_ready, !m_pend);
      check("freq_err", rq.freq_err, m_err);
    end
  task automatic request(input logic [31:0] hz);
    rq.freq_valid = 1'b1;
    rq.freq_hz = hz;
    @(negedge clk);
    rq.freq_valid = 1'b0;
  endtask
  task automatic window(input int n, output int ticks, output int highs, output int changes);
    logic last;
    ticks = 0; highs = 0; changes = 0;
    last = out_clk;
    repeat (n) begin
      @(negedge clk);
      ticks += int'(out_tick);
      highs += int'(out_clk);
      if (out_clk !== last) changes++;
      last = out_clk;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int t, h, c;
    rq.freq_valid = 1'b0;
    rq.freq_hz = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", rq.freq_ready, 1);
    check("rst_word", tuning_word, 0);
    check("rst_out_clk", out_clk, 0);
    check("rst_out_tick", out_tick, 0);
    check("rst_err", rq.freq_err, 0);
    rst = 1'b0;
    en = 1'b1;
    request(1_000_000);
    repeat (N) @(negedge clk);
    check("word_before_load", tuning_word, 0);
    check("ready_while_busy", rq.freq_ready, 0);
    @(negedge clk);
    check("word_1mhz", tuning_word, W1M);
    check("model_word_1mhz", m_word, W1M);
    check("ready_after_load", rq.freq_ready, 1);
    request(2_500_000);
    repeat (N + 1) @(negedge clk);
    check("word_2m5", tuning_word, 64'h4000_0000);
    window(16, t, h, c);
    check("ticks_2m5", t, 4);
    check("highs_2m5", h, 8);
    request(1_250_000);
    repeat (N + 1) @(negedge clk);
    check("word_1m25", tuning_word, 64'h2000_0000);
    window(32, t, h, c);
    check("ticks_1m25", t, 4);
    check("highs_1m25", h, 16);
    request(5_000_000);
    check("err_5mhz", rq.freq_err, 1);
    check("ready_on_err", rq.freq_ready, 1);
    check("word_kept_on_err", tuning_word, 64'h2000_0000);
    @(negedge clk);
    check("err_one_cycle", rq.freq_err, 0);
    request(32'hFFFF_FFFF);
    check("err_max", rq.freq_err, 1);
    request(32'h8000_0000);
    check("err_wrap33", rq.freq_err, 1);
    request(4_999_999);
    repeat (N + 1) @(negedge clk);
    check("word_boundary", tuning_word, WBND);
    check("model_word_boundary", m_word, WBND);
    request(0);
    repeat (N + 1) @(negedge clk);
    check("word_zero", tuning_word, 0);
    window(20, t, h, c);
    check("ticks_zero", t, 0);
    check("clk_frozen_zero", c, 0);
    rq.freq_valid = 1'b1;
    rq.freq_hz = 1_000_000;
    @(negedge clk);
    rq.freq_hz = 3_000_000;
    repeat (N) @(negedge clk);
    rq.freq_valid = 1'b0;
    @(negedge clk);
    check("word_busy_ignored", tuning_word, W1M);
    check("ready_busy_done", rq.freq_ready, 1);
    repeat (3) @(negedge clk);
    en = 1'b0;
    window(5, t, h, c);
    check("ticks_en_off", t, 0);
    check("clk_hold_en_off", c, 0);
    en = 1'b1;
    repeat (12) @(negedge clk);
    request(2_500_000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_word", tuning_word, 0);
    check("midrst_ready", rq.freq_ready, 1);
    check("midrst_err", rq.freq_err, 0);
    check("midrst_out_clk", out_clk, 0);
    check("midrst_out_tick", out_tick, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (N + 4) @(negedge clk);
    check("post_rst_ready", rq.freq_ready, 1);
    check("post_rst_word", tuning_word, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
